pc_status_unit: RTL

//  Execution-side end of the control word: consumes Psel/PCsel/EN_PC/SL fields emitted by the
//  per-opcode decoders, owns PC, the VCZN status register and the 2-bit instruction-state register.

---
 rtl/pc_status_unit.sv | 76 +++++++
 1 files changed

// File: rtl/pc_status_unit.sv
// pc_status_unit: execution-side owner of PC, the VCZN status flags and the
// 2-bit instruction state; also drives PC+4 for BL and counts branches.
module pc_status_unit #(
    parameter int unsigned     PC_WIDTH  = 64,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
    parameter int unsigned     CNT_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 stall,
    input  logic [1:0]           Psel,
    input  logic                 PCsel,
    input  logic                 EN_PC,
    input  logic                 SL,
    input  logic [3:0]           alu_flags,
    input  logic [PC_WIDTH-1:0]  K,
    input  logic [PC_WIDTH-1:0]  bus_in,
    input  logic [1:0]           nextState,
    output logic [PC_WIDTH-1:0]  pc,
    output logic [3:0]           status,
    output logic [1:0]           state,
    output logic [PC_WIDTH-1:0]  bus_out,
    output logic                 bus_out_en,
    output logic [CNT_WIDTH-1:0] branch_cnt,
    output logic                 align_fault
);

    logic [PC_WIDTH-1:0] pc_plus4;
    logic [PC_WIDTH-1:0] in_sel;
    logic [PC_WIDTH-1:0] pc_cand;
    logic [PC_WIDTH-1:0] pc_next;
    logic                misaligned;

    assign pc_plus4 = pc + PC_WIDTH'(4);
    assign in_sel   = PCsel ? K : bus_in;

    // Candidate next PC from Psel; misaligned targets are truncated to a word boundary
    always_comb begin
        pc_cand = pc;
        unique case (Psel)
            2'b00: pc_cand = pc;
            2'b01: pc_cand = pc_plus4;
            2'b10: pc_cand = in_sel;
            2'b11: pc_cand = pc_plus4 + (in_sel << 2);
        endcase
        misaligned = (Psel != 2'b00) && (pc_cand[1:0] != 2'b00);
        pc_next    = {pc_cand[PC_WIDTH-1:2], 2'b00};
    end

    // Return address for BL; reflects the current (pre-update) PC
    always_comb begin
        bus_out_en = EN_PC;
        bus_out    = EN_PC ? pc_plus4 : '0;
    end

    // Architectural state update; stall freezes everything, reset overrides asynchronously
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc          <= RESET_PC;
            status      <= '0;
            state       <= '0;
            branch_cnt  <= '0;
            align_fault <= 1'b0;
        end else if (!stall) begin
            pc    <= pc_next;
            state <= nextState;
            if (SL)
                status <= alu_flags;
            if (misaligned)
                align_fault <= 1'b1;
            if (Psel[1] && (branch_cnt != '1))
                branch_cnt <= branch_cnt + CNT_WIDTH'(1);
        end
    end

endmodule
